// File: rtl/playfield_renderer.sv
// -----------------------------------------------------------------------------
// playfield_renderer
//
// Maps the current VGA pixel (DrawX, DrawY) onto a Tetris playfield cell and
// returns that cell's colour index plus grid/field flags. Rows flagged in
// flash_rows blink during a line-clear animation, paced by a frame-strobe
// counter. Every pixel output passes through a fixed two-register pipeline.
//
// Ports
//   Clk          system clock, all state on the rising edge
//   Reset_n      asynchronous active-low reset (synchronous release upstream)
//   DrawX/DrawY  current pixel column / row from the VGA controller
//   field_i      packed cell colours; cell (r,c) at [((r*COLS)+c)*COLOR_W +: COLOR_W],
//                r=0 is the bottom row, c=0 the leftmost column
//   flash_rows   bit r set = row r is being cleared
//   flash_en     enables the line-clear blink
//   cell_color   colour of the addressed cell after flash masking (0 = empty)
//   is_block     cell_color != 0
//   in_field     pixel lies inside the field rectangle
//   is_edge      pixel is on the first column or row of a cell, inside the field
//   flash_phase  current blink phase; 1 = flashing rows blanked
// -----------------------------------------------------------------------------
module playfield_renderer #(
  parameter int CELL_W       = 20,
  parameter int CELL_H       = 20,
  parameter int COLS         = 10,
  parameter int ROWS         = 22,
  parameter int ORG_X        = 300,
  parameter int ORG_Y        = 0,
  parameter int COLOR_W      = 3,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic [ROWS*COLS*COLOR_W-1:0]  field_i,
  input  logic [ROWS-1:0]               flash_rows,
  input  logic                          flash_en,
  output logic [COLOR_W-1:0]            cell_color,
  output logic                          is_block,
  output logic                          in_field,
  output logic                          is_edge,
  output logic                          flash_phase
);

  // ---------------------------------------------------------------------------
  // Derived widths and 11-bit constants used by the coordinate arithmetic.
  // ---------------------------------------------------------------------------
  localparam int COL_W  = (COLS > 1)         ? $clog2(COLS)         : 1;
  localparam int ROW_W  = (ROWS > 1)         ? $clog2(ROWS)         : 1;
  localparam int SUBX_W = (CELL_W > 1)       ? $clog2(CELL_W)       : 1;
  localparam int SUBY_W = (CELL_H > 1)       ? $clog2(CELL_H)       : 1;
  localparam int IDX_W  = (ROWS * COLS > 1)  ? $clog2(ROWS * COLS)  : 1;
  localparam int CNT_W  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [10:0] ORG_X_L   = 11'(ORG_X);
  localparam logic [10:0] ORG_Y_L   = 11'(ORG_Y);
  localparam logic [10:0] FIELD_W_L = 11'(COLS * CELL_W);
  localparam logic [10:0] FIELD_H_L = 11'(ROWS * CELL_H);
  localparam logic [10:0] CELL_W_L  = 11'(CELL_W);
  localparam logic [10:0] CELL_H_L  = 11'(CELL_H);

  localparam logic [ROW_W-1:0] TOP_ROW  = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } flash_state_t;

  // ---------------------------------------------------------------------------
  // Stage 1: pixel -> (row, col, subx, suby) and the field-bounds test.
  // ---------------------------------------------------------------------------
  logic [10:0]       dx;
  logic [10:0]       dy;
  logic [10:0]       col_full;
  logic [10:0]       drow_full;
  logic [10:0]       subx_full;
  logic [10:0]       suby_full;
  logic              s1_in_field_d;
  logic [ROW_W-1:0]  s1_row_d;
  logic [COL_W-1:0]  s1_col_d;
  logic [SUBX_W-1:0] s1_subx_d;
  logic [SUBY_W-1:0] s1_suby_d;

  // Widened to 11 bits so a pixel left of / above the origin shows up as a
  // set MSB instead of wrapping into a large in-range offset.
  assign dx = {1'b0, DrawX} - ORG_X_L;
  assign dy = {1'b0, DrawY} - ORG_Y_L;

  // Constant divisors: these reduce to combinational logic, no iterative divider.
  assign col_full  = dx / CELL_W_L;
  assign drow_full = dy / CELL_H_L;
  assign subx_full = dx % CELL_W_L;
  assign suby_full = dy % CELL_H_L;

  // NOTE: every signal assigned in an always_comb gets a default on entry, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    s1_in_field_d = 1'b0;
    s1_row_d      = '0;
    s1_col_d      = '0;
    s1_subx_d     = '0;
    s1_suby_d     = '0;
    // Sign is checked first; the upper bound is exclusive on both axes.
    if (!dx[10] && !dy[10] && (dx < FIELD_W_L) && (dy < FIELD_H_L)) begin
      s1_in_field_d = 1'b1;
      s1_col_d      = COL_W'(col_full);
      // Display row 0 is the top of the field, which is field row ROWS-1.
      s1_row_d      = TOP_ROW - ROW_W'(drow_full);
      s1_subx_d     = SUBX_W'(subx_full);
      s1_suby_d     = SUBY_W'(suby_full);
    end
    // Outside the field row/col stay at 0 so stage 2 never indexes past the
    // end of field_i or flash_rows.
  end

  logic              s1_in_field;
  logic [ROW_W-1:0]  s1_row;
  logic [COL_W-1:0]  s1_col;
  logic [SUBX_W-1:0] s1_subx;
  logic [SUBY_W-1:0] s1_suby;

  // NOTE: clocked state uses non-blocking assignments so every register in
  // the pipeline samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_in_field <= 1'b0;
      s1_row      <= '0;
      s1_col      <= '0;
      s1_subx     <= '0;
      s1_suby     <= '0;
    end else begin
      s1_in_field <= s1_in_field_d;
      s1_row      <= s1_row_d;
      s1_col      <= s1_col_d;
      s1_subx     <= s1_subx_d;
      s1_suby     <= s1_suby_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame strobe: rising edge of "pixel is (0,0)". Holding the origin for
  // several cycles produces a single strobe.
  // ---------------------------------------------------------------------------
  logic at_origin;
  logic prev_origin;
  logic frame_strobe;

  assign at_origin    = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign frame_strobe = at_origin && !prev_origin;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_origin <= 1'b0;
    end else begin
      prev_origin <= at_origin;
    end
  end

  // ---------------------------------------------------------------------------
  // Flash FSM: counts frame strobes and toggles the blink phase every
  // FLASH_FRAMES frames while flash_en is held.
  // ---------------------------------------------------------------------------
  flash_state_t     state_q;
  flash_state_t     state_d;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] frame_cnt_d;
  logic             phase_q;
  logic             phase_d;
  logic             flash_mask_en;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    unique case (state_q)
      IDLE: begin
        frame_cnt_d = '0;
        phase_d     = 1'b0;
        if (flash_en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Dropping flash_en takes priority over a coincident strobe.
        if (!flash_en) begin
          state_d     = IDLE;
          frame_cnt_d = '0;
          phase_d     = 1'b0;
        end else if (frame_strobe) begin
          if (frame_cnt_q == CNT_LAST) begin
            frame_cnt_d = '0;
            phase_d     = !phase_q;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        frame_cnt_d = '0;
        phase_d     = 1'b0;
      end
    endcase
  end

  always_comb begin
    flash_phase   = phase_q;
    // Uses the live flash_en so a disable unmasks the very next output.
    flash_mask_en = flash_en && phase_q;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: cell lookup, flash masking and edge flag.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]   cell_idx;
  logic [COLOR_W-1:0] raw_color;
  logic [COLOR_W-1:0] s2_color_d;
  logic               s2_edge_d;

  // Stage 1 guarantees row < ROWS and col < COLS, so the product stays in range.
  assign cell_idx  = IDX_W'(s1_row) * IDX_W'(COLS) + IDX_W'(s1_col);
  assign raw_color = field_i[cell_idx * COLOR_W +: COLOR_W];

  always_comb begin
    s2_color_d = raw_color;
    if (!s1_in_field || (flash_mask_en && flash_rows[s1_row])) begin
      s2_color_d = '0;
    end
    s2_edge_d = s1_in_field && ((s1_subx == '0) || (s1_suby == '0));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cell_color <= '0;
      is_block   <= 1'b0;
      in_field   <= 1'b0;
      is_edge    <= 1'b0;
    end else begin
      cell_color <= s2_color_d;
      is_block   <= (s2_color_d != '0);
      in_field   <= s1_in_field;
      is_edge    <= s2_edge_d;
    end
  end

endmodule

// File: tb/tb_playfield_renderer.sv
// -----------------------------------------------------------------------------
// tb_playfield_renderer
//
// Directed bench for playfield_renderer with the default geometry
// (20x20 cells, 10x22 field at x=300, y=0) and FLASH_FRAMES=2. Inputs are
// driven on the falling clock edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_playfield_renderer;

  localparam int ROWS    = 22;
  localparam int COLS    = 10;
  localparam int COLOR_W = 3;

  logic                         Clk = 1'b0;
  logic                         Reset_n;
  logic [9:0]                   DrawX;
  logic [9:0]                   DrawY;
  logic [ROWS*COLS*COLOR_W-1:0] field_i;
  logic [ROWS-1:0]              flash_rows;
  logic                         flash_en;
  logic [COLOR_W-1:0]           cell_color;
  logic                         is_block;
  logic                         in_field;
  logic                         is_edge;
  logic                         flash_phase;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit         valid;
    int         x;
    int         y;
    logic [2:0] color;
    logic       blk;
    logic       inf;
    logic       edg;
  } exp_t;

  exp_t exp_q[$];

  playfield_renderer #(
    .CELL_W      (20),
    .CELL_H      (20),
    .COLS        (COLS),
    .ROWS        (ROWS),
    .ORG_X       (300),
    .ORG_Y       (0),
    .COLOR_W     (COLOR_W),
    .FLASH_FRAMES(2)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .field_i    (field_i),
    .flash_rows (flash_rows),
    .flash_en   (flash_en),
    .cell_color (cell_color),
    .is_block   (is_block),
    .in_field   (in_field),
    .is_edge    (is_edge),
    .flash_phase(flash_phase)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_px(input string tag, input logic [2:0] col, input logic blk,
                          input logic inf, input logic edg);
    check({tag, ".color"},    32'(cell_color), 32'(col));
    check({tag, ".is_block"}, 32'(is_block),   32'(blk));
    check({tag, ".in_field"}, 32'(in_field),   32'(inf));
    check({tag, ".is_edge"},  32'(is_edge),    32'(edg));
  endtask

  task automatic set_cell(input int r, input int c, input logic [2:0] v);
    field_i[((r * COLS) + c) * COLOR_W +: COLOR_W] = v;
  endtask

  task automatic drive(input int x, input int y);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  // Two falling edges after a drive: the pixel has crossed both registers.
  task automatic settle();
    @(negedge Clk);
    @(negedge Clk);
  endtask

  // One-cycle visit to (0,0), then back onto the flashing test pixel.
  task automatic strobe();
    drive(0, 0);
    drive(300, 430);
  endtask

  // Expected outputs for the sweep field: only cell (0,9) = 5.
  function automatic exp_t sweep_model(input int x, input int y);
    exp_t e;
    e.valid = 1'b1;
    e.x     = x;
    e.y     = y;
    e.inf   = (x >= 300) && (x < 500) && (y >= 0) && (y < 440);
    e.color = ((x >= 480) && (x < 500) && (y >= 420) && (y < 440)) ? 3'd5 : 3'd0;
    e.blk   = (e.color != 3'd0);
    e.edg   = e.inf && ((((x - 300) % 20) == 0) || ((y % 20) == 0));
    return e;
  endfunction

  // One pipelined step: check the pixel driven two falling edges ago, then
  // drive the next one (or queue an unchecked empty slot while draining).
  task automatic stream_step(input int x, input int y, input bit drv);
    exp_t e;
    @(negedge Clk);
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      if (e.valid) begin
        check_px($sformatf("sweep(%0d,%0d)", e.x, e.y), e.color, e.blk, e.inf, e.edg);
      end
    end
    if (drv) begin
      DrawX = 10'(x);
      DrawY = 10'(y);
      exp_q.push_back(sweep_model(x, y));
    end else begin
      e       = '{valid: 1'b0, x: 0, y: 0, color: 3'd0, blk: 1'b0, inf: 1'b0, edg: 1'b0};
      exp_q.push_back(e);
    end
  endtask

  initial begin
    int xs[10] = '{0, 299, 300, 301, 479, 480, 481, 499, 500, 639};
    int ys[8]  = '{0, 1, 419, 420, 421, 439, 440, 479};

    Reset_n    = 1'b0;
    DrawX      = 10'd5;
    DrawY      = 10'd5;
    field_i    = '0;
    flash_rows = '0;
    flash_en   = 1'b0;

    // ---- Reset state ----
    repeat (3) @(negedge Clk);
    check_px("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    check("reset.flash_phase", 32'(flash_phase), 32'd0);
    Reset_n = 1'b1;

    // ---- Bounds and orientation: all cells 1, (21,0)=2, (0,9)=6 ----
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        set_cell(r, c, 3'd1);
      end
    end
    set_cell(21, 0, 3'd2);
    set_cell(0, 9, 3'd6);

    drive(300, 0);   settle(); check_px("b(300,0)",   3'd2, 1'b1, 1'b1, 1'b1);
    drive(499, 439); settle(); check_px("b(499,439)", 3'd6, 1'b1, 1'b1, 1'b0);
    drive(500, 0);   settle(); check_px("b(500,0)",   3'd0, 1'b0, 1'b0, 1'b0);
    drive(299, 100); settle(); check_px("b(299,100)", 3'd0, 1'b0, 1'b0, 1'b0);
    drive(300, 440); settle(); check_px("b(300,440)", 3'd0, 1'b0, 1'b0, 1'b0);

    // ---- Edge grid ----
    drive(320, 25); settle(); check_px("e(320,25)", 3'd1, 1'b1, 1'b1, 1'b1);
    drive(321, 40); settle(); check_px("e(321,40)", 3'd1, 1'b1, 1'b1, 1'b1);
    drive(321, 41); settle(); check_px("e(321,41)", 3'd1, 1'b1, 1'b1, 1'b0);

    // ---- Pipelined sweep, one pixel per cycle: only cell (0,9)=5 ----
    field_i = '0;
    set_cell(0, 9, 3'd5);
    for (int yi = 0; yi < 8; yi++) begin
      for (int xi = 0; xi < 10; xi++) begin
        stream_step(xs[xi], ys[yi], 1'b1);
      end
    end
    stream_step(0, 0, 1'b0);
    stream_step(0, 0, 1'b0);
    exp_q.delete();

    // ---- Flash: row 0 flagged, cell (0,0)=3, FLASH_FRAMES=2 ----
    field_i    = '0;
    set_cell(0, 0, 3'd3);
    flash_rows = 22'd1;
    @(negedge Clk);
    flash_en = 1'b1;
    drive(300, 430); settle();
    check_px("f.pre", 3'd3, 1'b1, 1'b1, 1'b1);
    check("f.pre.phase", 32'(flash_phase), 32'd0);

    strobe(); check("f.s1.phase", 32'(flash_phase), 32'd0);
    strobe(); check("f.s2.phase", 32'(flash_phase), 32'd1);
    settle(); check_px("f.masked", 3'd0, 1'b0, 1'b1, 1'b1);

    strobe(); check("f.s3.phase", 32'(flash_phase), 32'd1);
    strobe(); check("f.s4.phase", 32'(flash_phase), 32'd0);
    settle(); check_px("f.unmasked", 3'd3, 1'b1, 1'b1, 1'b1);

    // Holding (0,0) for five cycles is one strobe: phase must never toggle.
    drive(0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check($sformatf("f.hold%0d.phase", i), 32'(flash_phase), 32'd0);
    end
    DrawX = 10'd300;
    DrawY = 10'd430;
    strobe(); check("f.s6.phase", 32'(flash_phase), 32'd1);
    settle(); check_px("f.masked2", 3'd0, 1'b0, 1'b1, 1'b1);

    // ---- Disable while phase=1 ----
    @(negedge Clk);
    flash_en = 1'b0;
    @(negedge Clk);
    check("d.phase", 32'(flash_phase), 32'd0);
    check_px("d.px", 3'd3, 1'b1, 1'b1, 1'b1);

    // ---- Strobe coinciding with flash_en falling: IDLE wins ----
    flash_en = 1'b1;
    @(negedge Clk);
    strobe(); check("c.s1.phase", 32'(flash_phase), 32'd0);
    @(negedge Clk);
    DrawX    = 10'd0;
    DrawY    = 10'd0;
    flash_en = 1'b0;
    drive(300, 430);
    check("c.phase", 32'(flash_phase), 32'd0);

    // ---- Reset mid-stream ----
    drive(300, 430);
    drive(301, 430);
    @(negedge Clk);
    check_px("r.pre", 3'd3, 1'b1, 1'b1, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    check_px("r.async", 3'd0, 1'b0, 1'b0, 1'b0);
    check("r.async.phase", 32'(flash_phase), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    DrawX   = 10'd300;
    DrawY   = 10'd430;
    @(negedge Clk);
    check_px("r.lat1", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    check_px("r.lat2", 3'd3, 1'b1, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
